axis_to_noc_packetizer: RTL and testbench
=========================================

# axis_to_noc_packetizer

Upstream NoC injection stage: accepts single AXI-Stream beats from a local producer, buffers them in a small FIFO and emits each beat as a two-flit NoC packet (head flit carrying routing info, tail flit carrying the payload) under credit-based flow control. Output flit format matches the 36-bit link consumed by the NoC-to-AXIS ejection adapter at the far router port. It is the injection half of the AXIS-over-NoC pair.

## Interface
- `FIFO_DEPTH`, 4, input beat buffer depth (power of 2, ≥2)
- `CREDITS`, 2, downstream flit buffer slots; initial credit count
- `SRC_ID`, 4'h0, 4-bit source node ID placed in head flit
- `DEST_ID`, 4'h1, 4-bit fixed destination (used when `AXIS2NOC_TDEST_EN` undefined)
- `clk` in 1 — clock
- `rst` in 1 — reset, asynchronous, active-high
- `axis_tvalid` in 1 — beat valid
- `axis_tready` out 1 — FIFO not full
- `axis_tdata` in 32 — payload
- `axis_tdest` in 4 — destination node (present only with `AXIS2NOC_TDEST_EN`)
- `noc_out` out 36 — [35] link valid, [34:32] ctrl {tail, head, valid}, [31:0] data
- `noc_credit_in` in 1 — one-cycle pulse, returns one flit slot
- `credit_overflow` out 1 — sticky error, credit returned while counter already at `CREDITS`

## Operation
- FIFO: first-word-fall-through; write on `axis_tvalid && axis_tready`; `axis_tready = !full`, combinational.
- Credit counter `cnt`, width `$clog2(CREDITS+1)`, reset to `CREDITS`. Decrement on every flit sent, increment on `noc_credit_in`; both in the same cycle leaves it unchanged. Return at `cnt==CREDITS` without a send: counter saturates, `credit_overflow` set until reset.
- FSM states:
  - IDLE: if FIFO non-empty and `cnt>0`, emit head, go to TAIL.
  - TAIL: if `cnt>0`, emit tail, pop FIFO, then:
    - if FIFO holds another entry after the pop and `cnt-1+credit_in>0`, go to HEAD_NEXT-equivalent behaviour by emitting head on the next cycle (implemented as return to IDLE with no bubble: IDLE condition evaluated combinationally from next values).
    - otherwise go to IDLE.
  - In TAIL with `cnt==0`: stall, `noc_out=0`.
- Head flit: `noc_out = {1'b1, 3'b011, dest[3:0], SRC_ID[3:0], 24'h0}`. Head peeks the FIFO; it does not pop.
- Tail flit: `noc_out = {1'b1, 3'b101, fifo_data}`.
- Any cycle with no flit sent: `noc_out = 36'h0`.
- `noc_out` is registered.

## Timing
- Reset values: `noc_out=0`, `axis_tready=1`, `credit_overflow=0`, `cnt=CREDITS`, FSM in IDLE, FIFO empty.
- Beat accepted at edge E0 → head on `noc_out` from E1, tail from E2. Latency 1 cycle to head.
- Sustained throughput is 1 beat per 2 cycles with head immediately following tail (no bubble), provided credits are available.
- With `CREDITS=2` and no returns, exactly one packet is sent, then output stalls.
- Reset mid-packet drops the FIFO contents and any half-sent packet; no tail is emitted after reset.
- `noc_credit_in` during reset is ignored.

## Configuration
- `AXIS2NOC_TDEST_EN` defined:
  - `axis_tdest` port exists.
  - Each FIFO entry stores {tdest, tdata}, 36 bits.
  - Head dest field = stored tdest.
- Undefined:
  - No `axis_tdest` port.
  - FIFO stores 32 bits.
  - Head dest field = `DEST_ID`.

## Structure
- Shared package `noc_flit_pkg`:
  - `FLIT_W=36`
  - bit indices `LINK_VALID_BIT=35`, `CTRL_VALID=32`, `CTRL_HEAD=33`, `CTRL_TAIL=34`
  - head-field offsets `HDR_DEST_LSB=28`, `HDR_SRC_LSB=24`
  - FSM state localparams
- Sub-module `axis2noc_fifo`: parameterised width/depth synchronous FWFT FIFO with full/empty flags and asynchronous reset.

## Test plan
- Single beat `tdata=32'hDEADBEEF`, `DEST_ID=1`, `SRC_ID=0` → `noc_out=36'hB_1000_0000` at E1, then `36'hD_DEADBEEF` at E2, then `0`; `cnt=0`.
- Credits exhausted: send 2 beats with no credit returns → first packet out, second head withheld (`noc_out=0`); pulse `noc_credit_in` twice → second head and tail emitted.
- Backpressure: hold `axis_tvalid=1` for 8 beats with credits returned every cycle → `axis_tready` drops once the FIFO holds 4 entries, all 8 packets emitted in order with no bubbles.
- Simultaneous: credit return on the same cycle as a tail send → `cnt` unchanged.
- Overflow: `noc_credit_in` pulse at `cnt=2` with no send → `credit_overflow=1`, `cnt` stays 2, and the flag holds until `rst`.
- Reset asserted the cycle after a head flit → `noc_out=0` immediately, FIFO empty, no tail flit after release, `cnt=CREDITS`.

Source files
------------

// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions for the AXIS-over-NoC adapter pair:
// link/flit bit positions, head-field offsets, packetizer FSM states
// and flit builder helpers.
package noc_flit_pkg;

  localparam int FLIT_W         = 36;
  localparam int PAYLOAD_W      = 32;
  localparam int LINK_VALID_BIT = 35;
  localparam int CTRL_TAIL      = 34;
  localparam int CTRL_HEAD      = 33;
  localparam int CTRL_VALID     = 32;
  localparam int HDR_DEST_LSB   = 28;
  localparam int HDR_SRC_LSB    = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,  // ready to emit a head flit
    ST_TAIL = 1'b1   // head sent, tail pending
  } pkt_state_e;

  // Head flit: link valid, ctrl {tail=0, head=1, valid=1}, dest, src, zero pad.
  function automatic logic [FLIT_W-1:0] make_head(input logic [3:0] dest,
                                                  input logic [3:0] src);
    logic [FLIT_W-1:0] f;
    f                     = {FLIT_W{1'b0}};
    f[LINK_VALID_BIT]     = 1'b1;
    f[CTRL_HEAD]          = 1'b1;
    f[CTRL_VALID]         = 1'b1;
    f[HDR_DEST_LSB +: 4]  = dest;
    f[HDR_SRC_LSB +: 4]   = src;
    return f;
  endfunction

  // Tail flit: link valid, ctrl {tail=1, head=0, valid=1}, payload.
  function automatic logic [FLIT_W-1:0] make_tail(input logic [PAYLOAD_W-1:0] data);
    logic [FLIT_W-1:0] f;
    f                   = {FLIT_W{1'b0}};
    f[LINK_VALID_BIT]   = 1'b1;
    f[CTRL_TAIL]        = 1'b1;
    f[CTRL_VALID]       = 1'b1;
    f[PAYLOAD_W-1:0]    = data;
    return f;
  endfunction

endpackage

// File: rtl/axis2noc_fifo.sv
// First-word-fall-through FIFO with full/empty flags and asynchronous
// active-high reset. rd_data always shows the oldest entry while !empty.
// Writes while full and reads while empty are ignored.
module axis2noc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == (AW+1)'(0));
  assign wr_ok_s = wr_en && !full;
  assign rd_ok_s = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since the flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/axis_to_noc_packetizer.sv
// AXI-Stream to NoC injection stage. Each buffered beat leaves as a
// head flit (routing) followed by a tail flit (payload) on a registered
// 36-bit link, gated by a downstream credit counter.
// Optional feature macro: AXIS2NOC_TDEST_EN -- adds axis_tdest and
// carries a per-beat destination through the FIFO into the head flit.
module axis_to_noc_packetizer
  import noc_flit_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         CREDITS    = 2,
  parameter logic [3:0] SRC_ID     = 4'h0,
  parameter logic [3:0] DEST_ID    = 4'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axis_tvalid,
  output logic              axis_tready,
  input  logic [31:0]       axis_tdata,
`ifdef AXIS2NOC_TDEST_EN
  input  logic [3:0]        axis_tdest,
`endif
  output logic [FLIT_W-1:0] noc_out,
  input  logic              noc_credit_in,
  output logic              credit_overflow
);

  localparam int CW = $clog2(CREDITS + 1);
`ifdef AXIS2NOC_TDEST_EN
  localparam int DW = PAYLOAD_W + 4;
`else
  localparam int DW = PAYLOAD_W;
`endif

  pkt_state_e        state_r;
  pkt_state_e        state_nxt_s;
  logic [FLIT_W-1:0] flit_nxt_s;
  logic              send_s;
  logic              pop_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_nxt_s;
  logic              ovf_set_s;
  logic              overflow_r;
  logic [DW-1:0]     fifo_wdata_s;
  logic [DW-1:0]     fifo_rdata_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [3:0]        head_dest_s;

`ifdef AXIS2NOC_TDEST_EN
  assign fifo_wdata_s = {axis_tdest, axis_tdata};
  assign head_dest_s  = fifo_rdata_s[DW-1 -: 4];
`else
  assign fifo_wdata_s = axis_tdata;
  assign head_dest_s  = DEST_ID;
`endif

  assign axis_tready     = !fifo_full_s;
  assign credit_overflow = overflow_r;

  axis2noc_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (axis_tvalid),
    .wr_data (fifo_wdata_s),
    .rd_en   (pop_s),
    .rd_data (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Packet FSM: head peeks the FIFO, tail pops it. Returning to IDLE after
  // a tail lets the next head go out on the very next cycle (no bubble).
  always_comb begin
    state_nxt_s = state_r;
    flit_nxt_s  = {FLIT_W{1'b0}};
    send_s      = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && (cnt_r != CW'(0))) begin
          flit_nxt_s  = make_head(head_dest_s, SRC_ID);
          send_s      = 1'b1;
          state_nxt_s = ST_TAIL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TAIL: begin
        if (cnt_r != CW'(0)) begin
          flit_nxt_s  = make_tail(fifo_rdata_s[PAYLOAD_W-1:0]);
          send_s      = 1'b1;
          pop_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TAIL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Credit arithmetic: send consumes, return replenishes, a return at full
  // credit without a send saturates and raises the sticky error.
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_set_s = 1'b0;
    if (send_s && !noc_credit_in) begin
      cnt_nxt_s = cnt_r - CW'(1);
    end else if (!send_s && noc_credit_in) begin
      if (cnt_r == CW'(CREDITS)) begin
        ovf_set_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // FSM state and registered link output; reset drops any half-sent packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      noc_out <= {FLIT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      noc_out <= flit_nxt_s;
    end
  end

  // Credit counter and sticky overflow flag; returns during reset are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= CW'(CREDITS);
      overflow_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      overflow_r <= overflow_r | ovf_set_s;
    end
  end

endmodule

// File: tb/tb_axis_to_noc_packetizer.sv
// Self-checking bench for axis_to_noc_packetizer (default parameters).
// A scoreboard queue receives the expected head/tail flits whenever a beat
// is accepted; a negedge monitor pops and compares every valid flit.
module tb_axis_to_noc_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        axis_tvalid = 1'b0;
  logic        axis_tready;
  logic [31:0] axis_tdata = 32'h0;
  logic [3:0]  axis_tdest = 4'h1;
  logic [35:0] noc_out;
  logic        noc_credit_in;
  logic        credit_overflow;

  logic        credit_man = 1'b0;
  logic        auto_credit = 1'b0;
  logic        auto_q = 1'b0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_exp;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign noc_credit_in = credit_man | auto_q;

  axis_to_noc_packetizer dut (
    .clk             (clk),
    .rst             (rst),
    .axis_tvalid     (axis_tvalid),
    .axis_tready     (axis_tready),
    .axis_tdata      (axis_tdata),
`ifdef AXIS2NOC_TDEST_EN
    .axis_tdest      (axis_tdest),
`endif
    .noc_out         (noc_out),
    .noc_credit_in   (noc_credit_in),
    .credit_overflow (credit_overflow)
  );

  function automatic logic [35:0] exp_head(input logic [3:0] d);
    return {1'b1, 3'b011, d, 4'h0, 24'h000000};
  endfunction

  function automatic logic [35:0] exp_tail(input logic [31:0] d);
    return {1'b1, 3'b101, d};
  endfunction

  // Downstream model: one credit back the cycle after each received flit.
  always @(negedge clk) begin
    auto_q = auto_credit && noc_out[35];
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (noc_out[35]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got %h, nothing expected", noc_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (noc_out !== mon_exp) begin
            miscompares++;
            $display("FAIL sb_flit: got %h, expected %h", noc_out, mon_exp);
          end
        end
      end else if (noc_out !== 36'h0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_idle: got %h, expected 0", noc_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Offer one beat; returns 1 time unit after the accepting edge.
  task automatic push_beat(input logic [31:0] d, input logic [3:0] dest);
    int waits;
    logic [3:0] edest;
    waits = 0;
    axis_tvalid = 1'b1;
    axis_tdata  = d;
    axis_tdest  = dest;
    while (!axis_tready && waits < 50) begin
      tick();
      waits++;
    end
    if (!axis_tready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: tready stuck at %b, expected 1", axis_tready);
      axis_tvalid = 1'b0;
    end else begin
      tick();
`ifdef AXIS2NOC_TDEST_EN
      edest = dest;
`else
      edest = 4'h1;
`endif
      exp_q.push_back(exp_head(edest));
      exp_q.push_back(exp_tail(d));
      axis_tvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    credit_man = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (noc_out !== 36'h0) begin
      miscompares++; $display("FAIL rst_noc_out: got %h, expected 0", noc_out);
    end
    credit_man = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (axis_tready !== 1'b1) begin
      miscompares++; $display("FAIL rst_tready: got %b, expected 1", axis_tready);
    end
    vectors++;
    if (credit_overflow !== 1'b0) begin
      miscompares++; $display("FAIL rst_overflow: got %b, expected 0", credit_overflow);
    end
    vectors++;
    if (dut.cnt_r !== 2'd2) begin
      miscompares++; $display("FAIL rst_cnt: got %0d, expected 2", dut.cnt_r);
    end
  endtask

  task automatic test_single();
    apply_reset();
    push_beat(32'hDEADBEEF, 4'h1);
    @(negedge clk);
    vectors++;
    if (noc_out !== 36'h0) begin
      miscompares++; $display("FAIL single_pre: got %h, expected 0", noc_out);
    end
    @(negedge clk);
    vectors++;
    if (noc_out !== 36'hB_1000_0000) begin
      miscompares++; $display("FAIL single_head: got %h, expected B10000000", noc_out);
    end
    @(negedge clk);
    vectors++;
    if (noc_out !== 36'hD_DEADBEEF) begin
      miscompares++; $display("FAIL single_tail: got %h, expected DDEADBEEF", noc_out);
    end
    @(negedge clk);
    vectors++;
    if (noc_out !== 36'h0) begin
      miscompares++; $display("FAIL single_post: got %h, expected 0", noc_out);
    end
    vectors++;
    if (dut.cnt_r !== 2'd0) begin
      miscompares++; $display("FAIL single_cnt: got %0d, expected 0", dut.cnt_r);
    end
  endtask

  task automatic test_credit_stall();
    int waits;
    apply_reset();
    push_beat(32'h1111_0001, 4'h1);
    push_beat(32'h2222_0002, 4'h1);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (noc_out !== 36'h0) begin
        miscompares++; $display("FAIL stall_hold: got %h, expected 0", noc_out);
      end
    end
    vectors++;
    if (exp_q.size() != 2) begin
      miscompares++; $display("FAIL stall_pending: got %0d flits pending, expected 2", exp_q.size());
    end
    tick();
    credit_man = 1'b1;
    tick();
    tick();
    credit_man = 1'b0;
    waits = 0;
    while (exp_q.size() != 0 && waits < 20) begin
      tick();
      waits++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL stall_resume: got %0d flits pending, expected 0", exp_q.size());
    end
    tick();
    vectors++;
    if (dut.cnt_r !== 2'd0) begin
      miscompares++; $display("FAIL stall_cnt: got %0d, expected 0", dut.cnt_r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] beats [8];
    int idx, valid_cnt, first, last, cyc;
    logic rdy, saw_full;
    apply_reset();
    for (int i = 0; i < 8; i++) beats[i] = 32'hC0DE_0000 + 32'(i * 7);
    idx = 0; valid_cnt = 0; first = -1; last = -1; cyc = 0; saw_full = 1'b0;
    auto_credit = 1'b1;
    axis_tvalid = 1'b1;
    axis_tdata  = beats[0];
    axis_tdest  = 4'h1;
    while (valid_cnt < 16 && cyc < 200) begin
      @(negedge clk);
      if (noc_out[35]) begin
        valid_cnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      rdy = axis_tready;
      if (!rdy) saw_full = 1'b1;
      @(posedge clk);
      if (axis_tvalid && rdy) begin
        exp_q.push_back(exp_head(4'h1));
        exp_q.push_back(exp_tail(beats[idx]));
        idx++;
      end
      #1;
      if (idx < 8) begin
        axis_tvalid = 1'b1;
        axis_tdata  = beats[idx];
      end else begin
        axis_tvalid = 1'b0;
      end
      cyc++;
    end
    vectors++;
    if (valid_cnt != 16) begin
      miscompares++; $display("FAIL b2b_count: got %0d flits, expected 16", valid_cnt);
    end
    vectors++;
    if (last - first + 1 != 16) begin
      miscompares++; $display("FAIL b2b_bubble: got span %0d, expected 16", last - first + 1);
    end
    vectors++;
    if (saw_full !== 1'b1) begin
      miscompares++; $display("FAIL b2b_backpressure: got tready-low %b, expected 1", saw_full);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL b2b_drain: got %0d pending, expected 0", exp_q.size());
    end
    auto_credit = 1'b0;
    repeat (3) tick();
    vectors++;
    if (dut.cnt_r !== 2'd2 || credit_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_credits: got cnt %0d ovf %b, expected cnt 2 ovf 0", dut.cnt_r, credit_overflow);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    push_beat(32'h0BAD_F00D, 4'h1);
    tick();
    credit_man = 1'b1;
    tick();
    credit_man = 1'b0;
    vectors++;
    if (dut.cnt_r !== 2'd1) begin
      miscompares++; $display("FAIL simul_cnt: got %0d, expected 1", dut.cnt_r);
    end
    vectors++;
    if (credit_overflow !== 1'b0) begin
      miscompares++; $display("FAIL simul_ovf: got %b, expected 0", credit_overflow);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    credit_man = 1'b1;
    tick();
    credit_man = 1'b0;
    vectors++;
    if (credit_overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_set: got %b, expected 1", credit_overflow);
    end
    vectors++;
    if (dut.cnt_r !== 2'd2) begin
      miscompares++; $display("FAIL ovf_cnt: got %0d, expected 2", dut.cnt_r);
    end
    push_beat(32'h7777_1234, 4'h1);
    repeat (4) tick();
    vectors++;
    if (credit_overflow !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ovf_sticky: got ovf %b pending %0d, expected ovf 1 pending 0", credit_overflow, exp_q.size());
    end
    apply_reset();
    vectors++;
    if (credit_overflow !== 1'b0) begin
      miscompares++; $display("FAIL ovf_clear: got %b, expected 0", credit_overflow);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    push_beat(32'h5A5A_A5A5, 4'h1);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (noc_out !== 36'hB_1000_0000) begin
      miscompares++; $display("FAIL rmid_head: got %h, expected B10000000", noc_out);
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    vectors++;
    if (noc_out !== 36'h0 || axis_tready !== 1'b1 || dut.cnt_r !== 2'd2) begin
      miscompares++;
      $display("FAIL rmid_async: got noc %h tready %b cnt %0d, expected 0 1 2", noc_out, axis_tready, dut.cnt_r);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (noc_out !== 36'h0) begin
        miscompares++; $display("FAIL rmid_no_tail: got %h, expected 0", noc_out);
      end
    end
    vectors++;
    if (dut.cnt_r !== 2'd2) begin
      miscompares++; $display("FAIL rmid_cnt: got %0d, expected 2", dut.cnt_r);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_credit_stall();
    test_back_to_back();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
